// File: rtl/cur_mb_loader_if.sv
// Start/done handshake, frame-memory read port and cur_mb buffer write port of cur_mb_loader.
// master = the loader itself; slave = controller, frame memory and buffer side.
interface cur_mb_loader_if #(
    parameter int ADDR_W       = 32,
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8
);
    logic                    start_i;
    logic [PIC_W_MB_LEN-1:0] mb_x_i;
    logic [PIC_H_MB_LEN-1:0] mb_y_i;
    logic                    done_o;

    logic                    rd_req_o;
    logic [ADDR_W-1:0]       rd_addr_o;
    logic                    rd_ack_i;
    logic [31:0]             rd_data_i;

    logic                    cmb_wen_o;
    logic [6:0]              cmb_addr_o;
    logic [31:0]             cmb_data_o;

    modport master (
        input  start_i, mb_x_i, mb_y_i, rd_ack_i, rd_data_i,
        output done_o, rd_req_o, rd_addr_o, cmb_wen_o, cmb_addr_o, cmb_data_o
    );

    modport slave (
        output start_i, mb_x_i, mb_y_i, rd_ack_i, rd_data_i,
        input  done_o, rd_req_o, rd_addr_o, cmb_wen_o, cmb_addr_o, cmb_data_o
    );
endinterface

// File: rtl/cur_mb_loader.sv
// Fetches the current MB from planar frame memory into the cur_mb buffer (Y 0..63, Cb 64..79, Cr 80..95).
// Chroma planes are loaded only when CUR_MB_LOADER_CHROMA_EN is defined; otherwise luma only.
module cur_mb_loader #(
    parameter int ADDR_W       = 32,
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PIC_W_MB_LEN-1:0] sys_x_total,
    input  logic [ADDR_W-1:0]       sys_luma_base,
    input  logic [ADDR_W-1:0]       sys_cb_base,
    input  logic [ADDR_W-1:0]       sys_cr_base,
    cur_mb_loader_if.master         bus
);
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LUMA,
        S_CB,
        S_CR,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          word_q, word_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                done_q, done_d;
    logic                wen_q, wen_d;
    logic [6:0]          caddr_q, caddr_d;
    logic [DATA_W-1:0]   cdata_q, cdata_d;

    logic [ADDR_W-1:0]   wy;
    logic [ADDR_W-1:0]   y0;
    logic [1:0]          col;
    logic                busy;

    assign wy = (ADDR_W'(sys_x_total) + 1'b1) << 2;
    assign y0 = sys_luma_base + ((ADDR_W'(bus.mb_y_i) * wy) << 4) + (ADDR_W'(bus.mb_x_i) << 2);

`ifdef CUR_MB_LOADER_CHROMA_EN
    logic [ADDR_W-1:0]   cb0_q, cb0_d;
    logic [ADDR_W-1:0]   cr0_q, cr0_d;
    logic [ADDR_W-1:0]   wc;
    logic [ADDR_W-1:0]   c_off;

    assign wc    = (ADDR_W'(sys_x_total) + 1'b1) << 1;
    assign c_off = ((ADDR_W'(bus.mb_y_i) * wc) << 3) + (ADDR_W'(bus.mb_x_i) << 1);
`else
    logic unused_chroma;
    assign unused_chroma = ^{sys_cb_base, sys_cr_base};
`endif

    assign busy = (state_q == S_LUMA) || (state_q == S_CB) || (state_q == S_CR);
    // Word index low bits are the column: 4 words per luma row, 2 per chroma row.
    assign col  = (state_q == S_LUMA) ? word_q[1:0] : {1'b0, word_q[0]};

    assign bus.rd_req_o   = busy;
    assign bus.rd_addr_o  = busy ? (base_q + ADDR_W'(col)) : '0;
    assign bus.done_o     = done_q;
    assign bus.cmb_wen_o  = wen_q;
    assign bus.cmb_addr_o = caddr_q;
    assign bus.cmb_data_o = cdata_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        base_d  = base_q;
        done_d  = done_q;
        wen_d   = 1'b0;
        caddr_d = caddr_q;
        cdata_d = cdata_q;
`ifdef CUR_MB_LOADER_CHROMA_EN
        cb0_d   = cb0_q;
        cr0_d   = cr0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_LUMA;
                    done_d  = 1'b0;
                    word_d  = '0;
                    base_d  = y0;
`ifdef CUR_MB_LOADER_CHROMA_EN
                    cb0_d   = sys_cb_base + c_off;
                    cr0_d   = sys_cr_base + c_off;
`endif
                end
            end
            S_LUMA, S_CB, S_CR: begin
                if (bus.rd_ack_i) begin
                    wen_d   = 1'b1;
                    caddr_d = word_q;
                    cdata_d = bus.rd_data_i;
                    word_d  = word_q + 7'd1;
                    if (state_q == S_LUMA) begin
                        if (word_q[1:0] == 2'd3) begin
                            base_d = base_q + wy;
                        end
                        if (word_q == 7'd63) begin
`ifdef CUR_MB_LOADER_CHROMA_EN
                            state_d = S_CB;
                            base_d  = cb0_q;
`else
                            state_d = S_FLUSH;
`endif
                        end
                    end
`ifdef CUR_MB_LOADER_CHROMA_EN
                    else begin
                        if (word_q[0]) begin
                            base_d = base_q + wc;
                        end
                        if (state_q == S_CB && word_q == 7'd79) begin
                            state_d = S_CR;
                            base_d  = cr0_q;
                        end
                        if (state_q == S_CR && word_q == 7'd95) begin
                            state_d = S_FLUSH;
                        end
                    end
`endif
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            caddr_q <= '0;
            cdata_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            base_q  <= base_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            caddr_q <= caddr_d;
            cdata_q <= cdata_d;
        end
    end

`ifdef CUR_MB_LOADER_CHROMA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb0_q <= '0;
            cr0_q <= '0;
        end else begin
            cb0_q <= cb0_d;
            cr0_q <= cr0_d;
        end
    end
`endif
endmodule

// File: tb/tb_cur_mb_loader.sv
// Directed bench for cur_mb_loader: address model, write scoreboard, stalls, restart and reset abort.
// Honours CUR_MB_LOADER_CHROMA_EN to select 96-word or 64-word expectations.
module tb_cur_mb_loader;
    localparam int AW = 32;
    localparam int WL = 8;
    localparam int HL = 8;
`ifdef CUR_MB_LOADER_CHROMA_EN
    localparam int NW       = 96;
    localparam int DONE_CYC = 98;
`else
    localparam int NW       = 64;
    localparam int DONE_CYC = 66;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WL-1:0] xt;
    logic [AW-1:0] lb, cbb, crb;

    int            n_pass = 0;
    int            n_total = 0;
    logic [38:0]   sbq[$];
    logic [31:0]   cbuf[128];
    int unsigned   cur_mx, cur_my;
    int            dc;

    cur_mb_loader_if #(.ADDR_W(AW), .PIC_W_MB_LEN(WL), .PIC_H_MB_LEN(HL)) bus ();

    cur_mb_loader #(.ADDR_W(AW), .PIC_W_MB_LEN(WL), .PIC_H_MB_LEN(HL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sys_x_total   (xt),
        .sys_luma_base (lb),
        .sys_cb_base   (cbb),
        .sys_cr_base   (crb),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Direct per-word formula; the DUT accumulates row bases instead.
    function automatic logic [AW-1:0] exp_addr(input int unsigned k);
        int unsigned x1;
        x1 = int'(xt) + 1;
        if (k < 64)
            exp_addr = lb + AW'((cur_my * 16 + k / 4) * x1 * 4 + cur_mx * 4 + k % 4);
        else if (k < 80)
            exp_addr = cbb + AW'((cur_my * 8 + (k - 64) / 2) * x1 * 2 + cur_mx * 2 + (k - 64) % 2);
        else
            exp_addr = crb + AW'((cur_my * 8 + (k - 80) / 2) * x1 * 2 + cur_mx * 2 + (k - 80) % 2);
    endfunction

    task automatic run_load(input int unsigned mx, input int unsigned my, input bit stall,
                            input logic [31:0] salt, input int restart_at, input int reset_word,
                            output int done_cyc);
        int          acks;
        int          writes;
        int          maxa;
        int          n;
        bit          ack;
        bit          last_req;
        bit          last_ack;
        logic [AW-1:0] last_addr;
        logic [AW-1:0] ea;
        logic [38:0] e;
        acks = 0; writes = 0; maxa = 0; n = 0;
        ack = 1'b0; last_req = 1'b0; last_ack = 1'b0; last_addr = '0;
        done_cyc = -1;
        cur_mx = mx;
        cur_my = my;
        sbq.delete();
        bus.mb_x_i  = WL'(mx);
        bus.mb_y_i  = HL'(my);
        bus.start_i = 1'b1;
        @(negedge clk);
        n = 1;
        while (n < 3000) begin
            if (bus.cmb_wen_o) begin
                if (sbq.size() == 0) begin
                    check("unexpected_write", 64'(bus.cmb_addr_o), 64'h7f);
                end else begin
                    e = sbq.pop_front();
                    check("cmb_addr", 64'(bus.cmb_addr_o), 64'(e[38:32]));
                    check("cmb_data", 64'(bus.cmb_data_o), 64'(e[31:0]));
                end
                writes++;
                cbuf[bus.cmb_addr_o] = bus.cmb_data_o;
                if (int'(bus.cmb_addr_o) > maxa) maxa = int'(bus.cmb_addr_o);
            end
            if (bus.done_o) begin
                done_cyc = n;
                break;
            end
            if (n == restart_at) begin
                bus.start_i = 1'b1;
                bus.mb_x_i  = WL'(5);
                bus.mb_y_i  = HL'(5);
            end else begin
                bus.start_i = 1'b0;
            end
            if (reset_word >= 0 && acks == reset_word) begin
                bus.rd_ack_i = 1'b0;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check("rst_done",  64'(bus.done_o), 64'd0);
                check("rst_req",   64'(bus.rd_req_o), 64'd0);
                check("rst_addr",  64'(bus.rd_addr_o), 64'd0);
                check("rst_wen",   64'(bus.cmb_wen_o), 64'd0);
                check("rst_caddr", 64'(bus.cmb_addr_o), 64'd0);
                check("rst_cdata", 64'(bus.cmb_data_o), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                sbq.delete();
                @(negedge clk);
                return;
            end
            ack = 1'b0;
            if (bus.rd_req_o) begin
                if (last_req && !last_ack) check("addr_hold", 64'(bus.rd_addr_o), 64'(last_addr));
                ack = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
                if (ack) begin
                    ea = exp_addr(acks);
                    check("rd_addr", 64'(bus.rd_addr_o), 64'(ea));
                    bus.rd_data_i = bus.rd_addr_o ^ salt;
                    sbq.push_back({acks[6:0], ea ^ salt});
                    acks++;
                end
                last_addr = bus.rd_addr_o;
            end
            bus.rd_ack_i = ack;
            last_req = bus.rd_req_o;
            last_ack = ack;
            @(negedge clk);
            n++;
        end
        bus.rd_ack_i = 1'b0;
        check("done_seen", 64'(done_cyc > 0), 64'd1);
        check("ack_count", 64'(acks), 64'(NW));
        check("write_count", 64'(writes), 64'(NW));
        check("max_cmb_addr", 64'(maxa), 64'(NW - 1));
        check("queue_empty", 64'(sbq.size()), 64'd0);
        check("req_idle", 64'(bus.rd_req_o), 64'd0);
        @(negedge clk);
        check("done_hold", 64'(bus.done_o), 64'd1);
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.mb_x_i    = '0;
        bus.mb_y_i    = '0;
        bus.rd_ack_i  = 1'b0;
        bus.rd_data_i = '0;
        xt = '0; lb = '0; cbb = '0; crb = '0;
        repeat (3) @(negedge clk);
        check("reset_done",  64'(bus.done_o), 64'd0);
        check("reset_req",   64'(bus.rd_req_o), 64'd0);
        check("reset_addr",  64'(bus.rd_addr_o), 64'd0);
        check("reset_wen",   64'(bus.cmb_wen_o), 64'd0);
        check("reset_caddr", 64'(bus.cmb_addr_o), 64'd0);
        check("reset_cdata", 64'(bus.cmb_data_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single-MB picture, identity memory, ack tied high
        xt = 8'd0; lb = 32'h0; cbb = 32'h1000; crb = 32'h2000;
        run_load(0, 0, 1'b0, 32'h0, -1, -1, dc);
        check("t1_done_cycle", 64'(dc), 64'(DONE_CYC));
        check("t1_buf0", 64'(cbuf[0]), 64'd0);
        check("t1_buf3", 64'(cbuf[3]), 64'd3);
`ifdef CUR_MB_LOADER_CHROMA_EN
        check("t1_buf64", 64'(cbuf[64]), 64'h1000);
        check("t1_buf80", 64'(cbuf[80]), 64'h2000);
`endif

        // Test 2: 4-MB-wide picture, MB(2,1): Y starts at 264, Cb at cb_base+68
        xt = 8'd3; lb = 32'h0; cbb = 32'h4000; crb = 32'h8000;
        run_load(2, 1, 1'b0, 32'h5a5a_0000, -1, -1, dc);
        check("t2_done_cycle", 64'(dc), 64'(DONE_CYC));
        check("t2_buf0", 64'(cbuf[0]), 64'(32'd264 ^ 32'h5a5a_0000));

        // Test 3: random stalls, luma base near the top of the address space
        xt = 8'd5; lb = 32'hFFFF_FE00; cbb = 32'h0001_2340; crb = 32'hFFFF_FFF0;
        run_load(3, 2, 1'b1, $urandom, -1, -1, dc);

        // Test 4: second start mid-load must be ignored
        xt = 8'd7; lb = 32'h0010_0000; cbb = 32'h0020_0000; crb = 32'h0030_0000;
        run_load(1, 1, 1'b0, 32'h0, 30, -1, dc);
        check("t4_done_cycle", 64'(dc), 64'(DONE_CYC));

        // Test 5: reset at word 40, then a complete fresh load
        run_load(2, 2, 1'b0, 32'h0, -1, 40, dc);
        run_load(4, 3, 1'b0, 32'hC0DE_0000, -1, -1, dc);
        check("t5_done_cycle", 64'(dc), 64'(DONE_CYC));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
